// File: rtl/mod_check_pkg.sv
// Shared types and constants for the arbitrated modulo-residue scheduler.
// The state encoding is fixed so that waveform decoders and other blocks can rely on it.
package mod_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;
    localparam int   NUM_REQ = 2;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_MOD   = 5;

endpackage

// File: rtl/mod_residue_core.sv
// Bit-serial residue engine: consumes one operand bit per enabled cycle, MSB first,
// and keeps the running value of the operand modulo MOD.
module mod_residue_core
    import mod_check_pkg::*;
#(
    parameter  int MOD = DEFAULT_MOD,
    localparam int RW  = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [RW-1:0] residue
);

    localparam logic [RW:0] MOD_EXT = (RW+1)'(MOD);

    logic [RW-1:0] residue_reg;
    logic [RW-1:0] residue_next;
    logic [RW:0]   doubled;

    // 2*r + bit never exceeds 2*MOD-1, so a single conditional subtract keeps it below MOD.
    always_comb begin
        doubled      = {residue_reg, bit_in};
        residue_next = doubled[RW-1:0];
        if (doubled >= MOD_EXT) begin
            residue_next = RW'(doubled - MOD_EXT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            residue_reg <= '0;
        end else if (clr) begin
            residue_reg <= '0;
        end else if (en) begin
            residue_reg <= residue_next;
        end
    end

    assign residue = residue_reg;

endmodule

// File: rtl/mod_check_scheduler.sv
// Two-requester round-robin front end for the serial residue engine: accepts one word,
// shifts it MSB-first through the engine and returns a one-cycle tagged response.
module mod_check_scheduler
    import mod_check_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int MOD   = DEFAULT_MOD,
    localparam int RW    = $clog2(MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [RW-1:0]    rsp_residue,
    output logic             rsp_divisible,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] sr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             id_reg;
    logic             prio_reg;
    logic             rsp_id_reg;
    logic [RW-1:0]    rsp_residue_reg;

    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] ready_vec;
    logic               grant_id;
    logic               accept;
    logic [WIDTH-1:0]   grant_data;
    logic               in_done;
    logic [RW-1:0]      core_residue;

    assign valid_vec = {req1_valid, req0_valid};

    // With a single requester active the grant simply follows it; contention goes to prio.
    always_comb begin
        grant_id = valid_vec[1];
        if (&valid_vec) begin
            grant_id = prio_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = reset && (state_reg == IDLE) && valid_vec[gi]
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[ID_REQ0];
    assign req1_ready = ready_vec[ID_REQ1];
    assign accept     = |ready_vec;
    assign grant_data = grant_id ? req1_data : req0_data;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            cnt_reg         <= '0;
            id_reg          <= 1'b0;
            prio_reg        <= 1'b0;
            rsp_id_reg      <= 1'b0;
            rsp_residue_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                sr_reg   <= grant_data;
                cnt_reg  <= CW'(WIDTH - 1);
                id_reg   <= grant_id;
                prio_reg <= ~grant_id;
            end else if (state_reg == SHIFT) begin
                sr_reg <= sr_reg << 1;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end
            // Capture the finished result so it survives the engine clear on the next accept.
            if (state_reg == DONE) begin
                rsp_id_reg      <= id_reg;
                rsp_residue_reg <= core_residue;
            end
        end
    end

    mod_residue_core #(
        .MOD (MOD)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (state_reg == SHIFT),
        .bit_in  (sr_reg[WIDTH-1]),
        .residue (core_residue)
    );

    // In DONE the live engine result is shown; afterwards the captured copy holds it.
    assign in_done       = reset && (state_reg == DONE);
    assign rsp_valid     = in_done;
    assign rsp_id        = in_done ? id_reg : rsp_id_reg;
    assign rsp_residue   = in_done ? core_residue : rsp_residue_reg;
    assign rsp_divisible = (rsp_residue == '0);
    assign busy          = reset && (state_reg != IDLE);

endmodule
